baccarat_fsm: RTL

- Control state machine for the Baccarat datapath, i.e. the initiator side of the load/score interface.
- Issues one-hot card-load strobes in dealing order, reads back the player and dealer scores and the player's third card, and applies the Baccarat drawing rules.
- Drives the win lights once the hand is complete.
- One hand is played per reset; the block advances on each slow_clock edge (the pushbutton clock).

---
 rtl/baccarat_pkg.sv | 27 ++
 rtl/banker_rule.sv | 31 +++
 rtl/baccarat_fsm.sv | 94 +++++++++
 3 files changed

// File: rtl/baccarat_pkg.sv
// Shared types, rule thresholds and card helpers for the Baccarat controller.
// Imported by the top-level FSM and by the banker drawing-rule block.
package baccarat_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_P1,
    S_D1,
    S_P2,
    S_D2,
    S_CHK,
    S_P3,
    S_CHKD,
    S_D3,
    S_DONE
  } state_t;

  localparam logic [3:0] NATURAL_MIN      = 4'd8;
  localparam logic [3:0] PLAYER_STAND_MIN = 4'd6;
  localparam logic [3:0] BANKER_STAND_MIN = 4'd7;

  // Face cards and tens count as zero; rank 0 means the slot is empty.
  function automatic logic [3:0] card_value(input logic [3:0] rank);
    card_value = ((rank >= 4'd1) && (rank <= 4'd9)) ? rank : 4'd0;
  endfunction

endpackage

// File: rtl/banker_rule.sv
// Banker third-card decision from the banker's two-card score and, when the
// player drew, the value of the player's third card.
module banker_rule
  import baccarat_pkg::*;
(
  input  logic [3:0] dscore,
  input  logic [3:0] pcard3,
  input  logic       player_drew,
  output logic       draw
);

  logic [3:0] v;

  always_comb begin
    v    = card_value(pcard3);
    draw = 1'b0;
    if (!player_drew) begin
      // A banker facing a standing player follows the player's own threshold.
      draw = (dscore < PLAYER_STAND_MIN);
    end else if (dscore < BANKER_STAND_MIN) begin
      case (dscore)
        4'd3:    draw = (v != 4'd8);
        4'd4:    draw = (v >= 4'd2) && (v <= 4'd7);
        4'd5:    draw = (v >= 4'd4) && (v <= 4'd7);
        4'd6:    draw = (v >= 4'd6) && (v <= 4'd7);
        default: draw = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/baccarat_fsm.sv
// Moore controller for one Baccarat hand: deals cards via one-hot load strobes,
// applies the drawing rules and lights the winner once the hand is complete.
module baccarat_fsm
  import baccarat_pkg::*;
(
  input  logic       slow_clock,
  input  logic       resetb,
  input  logic [3:0] pscore,
  input  logic [3:0] dscore,
  input  logic [3:0] pcard3,
  output logic       load_pcard1,
  output logic       load_pcard2,
  output logic       load_pcard3,
  output logic       load_dcard1,
  output logic       load_dcard2,
  output logic       load_dcard3,
  output logic       player_win_light,
  output logic       dealer_win_light
);

  state_t state_reg, state_next;
  logic   player_drew_reg;
  logic   banker_draw;

  banker_rule u_banker_rule (
    .dscore      (dscore),
    .pcard3      (pcard3),
    .player_drew (player_drew_reg),
    .draw        (banker_draw)
  );

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      state_reg       <= S_IDLE;
      player_drew_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == S_CHK) player_drew_reg <= (state_next == S_P3);
    end
  end

  always_comb begin
    state_next       = S_IDLE;
    load_pcard1      = 1'b0;
    load_pcard2      = 1'b0;
    load_pcard3      = 1'b0;
    load_dcard1      = 1'b0;
    load_dcard2      = 1'b0;
    load_dcard3      = 1'b0;
    player_win_light = 1'b0;
    dealer_win_light = 1'b0;
    case (state_reg)
      S_IDLE: state_next = S_P1;
      S_P1: begin
        load_pcard1 = 1'b1;
        state_next  = S_D1;
      end
      S_D1: begin
        load_dcard1 = 1'b1;
        state_next  = S_P2;
      end
      S_P2: begin
        load_pcard2 = 1'b1;
        state_next  = S_D2;
      end
      S_D2: begin
        load_dcard2 = 1'b1;
        state_next  = S_CHK;
      end
      S_CHK: begin
        if ((pscore >= NATURAL_MIN) || (dscore >= NATURAL_MIN)) state_next = S_DONE;
        else if (pscore < PLAYER_STAND_MIN)                     state_next = S_P3;
        else                                                    state_next = S_CHKD;
      end
      S_P3: begin
        load_pcard3 = 1'b1;
        state_next  = S_CHKD;
      end
      S_CHKD: state_next = banker_draw ? S_D3 : S_DONE;
      S_D3: begin
        load_dcard3 = 1'b1;
        state_next  = S_DONE;
      end
      S_DONE: begin
        // Scores are stable here since no further loads occur.
        state_next       = S_DONE;
        player_win_light = (pscore >= dscore);
        dealer_win_light = (dscore >= pscore);
      end
      default: state_next = S_IDLE;
    endcase
  end

endmodule
